// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_INIT = 2'd0,
    HZ_RUN  = 2'd1,
    HZ_MISS = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when an ID source operand really depends on a non-x0 EX destination.
  function automatic logic src_hit(input logic [4:0] rd, input logic [4:0] rs, input logic used);
    return used && (rd == rs) && (rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Single wrap-around performance counter with increment enable.
module hazard_perf_cnt
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  output logic [CNT_W-1:0] count
);

  // Counter register; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc_en) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: post-reset flush, dcache miss stall, redirect
// and load-use handling for the five-stage RV32 core, plus hazard counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int INIT_FLUSH_CYCLES = 2,
  parameter int CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             rs1_used_ID,
  input  logic             rs2_used_ID,
  input  logic [4:0]       rd_EX,
  input  logic             reg_write_en_EX,
  input  logic             mem_read_EX,
  input  logic             br_EX,
  input  logic             jalr_EX,
  input  logic             jal_ID,
  input  logic             dcache_miss_MEM,
  input  logic             dcache_done,
  output logic             bubbleF,
  output logic             bubbleD,
  output logic             bubbleE,
  output logic             bubbleM,
  output logic             bubbleW,
  output logic             flushF,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] redirect_count
);

  localparam logic [3:0] INIT_LOAD = 4'(INIT_FLUSH_CYCLES);

  hz_state_e  state_r;
  hz_state_e  next_state_s;
  logic [3:0] init_cnt_r;
  logic [3:0] init_cnt_next_s;
  logic [4:0] bubble_s;
  logic [4:0] flush_s;
  logic       apply_rules_s;
  logic       miss_inc_s;
  logic       redirect_inc_s;
  logic       stall_inc_s;
  logic       redirect_ex_s;
  logic       load_use_s;

  assign redirect_ex_s = br_EX | jalr_EX;
  assign load_use_s    = mem_read_EX & reg_write_en_EX &
                         (src_hit(rd_EX, rs1_ID, rs1_used_ID) |
                          src_hit(rd_EX, rs2_ID, rs2_used_ID));

  // State and INIT down-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= HZ_INIT;
      init_cnt_r <= INIT_LOAD;
    end else begin
      state_r    <= next_state_s;
      init_cnt_r <= init_cnt_next_s;
    end
  end

  // Next-state and hazard outputs; bit 4 of each vector is the F stage.
  always_comb begin
    next_state_s    = state_r;
    init_cnt_next_s = init_cnt_r;
    bubble_s        = 5'b00000;
    flush_s         = 5'b00000;
    apply_rules_s   = 1'b0;
    miss_inc_s      = 1'b0;
    redirect_inc_s  = 1'b0;
    case (state_r)
      HZ_INIT: begin
        flush_s = 5'b11111;
        if (init_cnt_r <= 4'd1) begin
          next_state_s    = HZ_RUN;
          init_cnt_next_s = 4'd0;
        end else begin
          init_cnt_next_s = init_cnt_r - 4'd1;
        end
      end
      HZ_RUN: begin
        if (dcache_miss_MEM) begin
          bubble_s     = 5'b11110;
          flush_s      = 5'b00001;
          next_state_s = HZ_MISS;
          miss_inc_s   = 1'b1;
        end else begin
          apply_rules_s = 1'b1;
        end
      end
      HZ_MISS: begin
        // Release is Mealy: the done cycle already obeys the RUN rules.
        if (dcache_done) begin
          apply_rules_s = 1'b1;
          next_state_s  = HZ_RUN;
        end else begin
          bubble_s = 5'b11110;
          flush_s  = 5'b00001;
        end
      end
      default: begin
        next_state_s    = HZ_INIT;
        init_cnt_next_s = INIT_LOAD;
        flush_s         = 5'b11111;
      end
    endcase

    // Redirects discard the ID instruction, so they outrank load-use.
    if (apply_rules_s) begin
      if (redirect_ex_s) begin
        flush_s        = 5'b01100;
        redirect_inc_s = 1'b1;
      end else if (jal_ID) begin
        flush_s        = 5'b01000;
        redirect_inc_s = 1'b1;
      end else if (load_use_s) begin
        bubble_s = 5'b11000;
        flush_s  = 5'b00100;
      end else begin
        bubble_s = 5'b00000;
        flush_s  = 5'b00000;
      end
    end else begin
      redirect_inc_s = 1'b0;
    end
  end

  assign stall_inc_s = bubble_s[4] & (state_r != HZ_INIT);

  assign {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW} = bubble_s;
  assign {flushF,  flushD,  flushE,  flushM,  flushW}  = flush_s;

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc_en (stall_inc_s),
    .count  (stall_cycles)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc_en (miss_inc_s),
    .count  (miss_count)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc_en (redirect_inc_s),
    .count  (redirect_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (default counters and a 4-bit copy).
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_ID, rs2_ID, rd_EX;
  logic        rs1_used_ID, rs2_used_ID, reg_write_en_EX, mem_read_EX;
  logic        br_EX, jalr_EX, jal_ID, dcache_miss_MEM, dcache_done;
  logic        bF, bD, bE, bM, bW, fF, fD, fE, fM, fW;
  logic        b4F, b4D, b4E, b4M, b4W, f4F, f4D, f4E, f4M, f4W;
  logic [31:0] stall_cycles, miss_count, redirect_count;
  logic [3:0]  stall4, miss4, redir4;
  logic [4:0]  bub, fl, bub4, fl4;
  int          checks;
  int          errors;
  logic [31:0] exp_stall, exp_miss, exp_redir;

  assign bub  = {bF, bD, bE, bM, bW};
  assign fl   = {fF, fD, fE, fM, fW};
  assign bub4 = {b4F, b4D, b4E, b4M, b4W};
  assign fl4  = {f4F, f4D, f4E, f4M, f4W};

  hazard_ctrl #(.INIT_FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID), .rd_EX(rd_EX),
    .reg_write_en_EX(reg_write_en_EX), .mem_read_EX(mem_read_EX), .br_EX(br_EX),
    .jalr_EX(jalr_EX), .jal_ID(jal_ID), .dcache_miss_MEM(dcache_miss_MEM),
    .dcache_done(dcache_done),
    .bubbleF(bF), .bubbleD(bD), .bubbleE(bE), .bubbleM(bM), .bubbleW(bW),
    .flushF(fF), .flushD(fD), .flushE(fE), .flushM(fM), .flushW(fW),
    .stall_cycles(stall_cycles), .miss_count(miss_count), .redirect_count(redirect_count)
  );

  hazard_ctrl #(.INIT_FLUSH_CYCLES(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID), .rd_EX(rd_EX),
    .reg_write_en_EX(reg_write_en_EX), .mem_read_EX(mem_read_EX), .br_EX(br_EX),
    .jalr_EX(jalr_EX), .jal_ID(jal_ID), .dcache_miss_MEM(dcache_miss_MEM),
    .dcache_done(dcache_done),
    .bubbleF(b4F), .bubbleD(b4D), .bubbleE(b4E), .bubbleM(b4M), .bubbleW(b4W),
    .flushF(f4F), .flushD(f4D), .flushE(f4E), .flushM(f4M), .flushW(f4W),
    .stall_cycles(stall4), .miss_count(miss4), .redirect_count(redir4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_ID = 5'd0; rs2_ID = 5'd0; rd_EX = 5'd0;
    rs1_used_ID = 1'b0; rs2_used_ID = 1'b0; reg_write_en_EX = 1'b0; mem_read_EX = 1'b0;
    br_EX = 1'b0; jalr_EX = 1'b0; jal_ID = 1'b0; dcache_miss_MEM = 1'b0; dcache_done = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs2);
    mem_read_EX = 1'b1; reg_write_en_EX = 1'b1; rd_EX = rd; rs2_ID = rs2; rs2_used_ID = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    cyc(); cyc();
    checks++; if (fl !== 5'b11111) begin errors++; $display("FAIL rst_flush got %b exp %b", fl, 5'b11111); end
    checks++; if (bub !== 5'b00000) begin errors++; $display("FAIL rst_bubble got %b exp %b", bub, 5'b00000); end
    checks++; if (fl4 !== 5'b11111 || bub4 !== 5'b00000) begin errors++; $display("FAIL rst_dut4 got %b/%b exp 11111/00000", fl4, bub4); end
    rst = 1'b0;
    #1;
    checks++; if (fl !== 5'b11111) begin errors++; $display("FAIL init_edge1_flush got %b exp %b", fl, 5'b11111); end
    cyc();
    checks++; if (fl !== 5'b11111 || bub !== 5'b00000) begin errors++; $display("FAIL init_edge2_flush got %b/%b exp 11111/00000", fl, bub); end
    cyc();
    checks++; if (fl !== 5'b00000 || bub !== 5'b00000) begin errors++; $display("FAIL run_idle got %b/%b exp 00000/00000", fl, bub); end
    checks++; if (stall_cycles !== 32'd0 || miss_count !== 32'd0 || redirect_count !== 32'd0) begin
      errors++; $display("FAIL rst_counters got %0d/%0d/%0d exp 0/0/0", stall_cycles, miss_count, redirect_count); end
    exp_stall = 32'd0; exp_miss = 32'd0; exp_redir = 32'd0;
  endtask

  task automatic test_load_use();
    set_load_use(5'd5, 5'd5);
    #1;
    checks++; if (bub !== 5'b11000 || fl !== 5'b00100) begin errors++; $display("FAIL lu_rs2 got %b/%b exp 11000/00100", bub, fl); end
    checks++; if (bub4 !== 5'b11000 || fl4 !== 5'b00100) begin errors++; $display("FAIL lu_rs2_dut4 got %b/%b exp 11000/00100", bub4, fl4); end
    cyc(); exp_stall = exp_stall + 32'd1;
    clear_inputs();
    #1;
    checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL lu_stall got %0d exp %0d", stall_cycles, exp_stall); end
    checks++; if (bub !== 5'b00000 || fl !== 5'b00000) begin errors++; $display("FAIL lu_one_cycle got %b/%b exp 00000/00000", bub, fl); end
    set_load_use(5'd0, 5'd0);
    #1;
    checks++; if (bub !== 5'b00000 || fl !== 5'b00000) begin errors++; $display("FAIL lu_x0 got %b/%b exp 00000/00000", bub, fl); end
    cyc();
    clear_inputs();
    mem_read_EX = 1'b1; reg_write_en_EX = 1'b1; rd_EX = 5'd7; rs1_ID = 5'd7; rs1_used_ID = 1'b1;
    #1;
    checks++; if (bub !== 5'b11000 || fl !== 5'b00100) begin errors++; $display("FAIL lu_rs1 got %b/%b exp 11000/00100", bub, fl); end
    cyc(); exp_stall = exp_stall + 32'd1;
    rs1_used_ID = 1'b0;
    #1;
    checks++; if (bub !== 5'b00000) begin errors++; $display("FAIL lu_unused got %b exp %b", bub, 5'b00000); end
    checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL lu_stall2 got %0d exp %0d", stall_cycles, exp_stall); end
    cyc();
    clear_inputs();
  endtask

  task automatic test_redirect();
    set_load_use(5'd5, 5'd5);
    br_EX = 1'b1; jal_ID = 1'b1;
    #1;
    checks++; if (fl !== 5'b01100 || bub !== 5'b00000) begin errors++; $display("FAIL redir_prio got %b/%b exp 01100/00000", fl, bub); end
    cyc(); exp_redir = exp_redir + 32'd1;
    clear_inputs(); jal_ID = 1'b1;
    #1;
    checks++; if (redirect_count !== exp_redir || stall_cycles !== exp_stall) begin
      errors++; $display("FAIL redir_count1 got %0d/%0d exp %0d/%0d", redirect_count, stall_cycles, exp_redir, exp_stall); end
    checks++; if (fl !== 5'b01000 || bub !== 5'b00000) begin errors++; $display("FAIL jal_only got %b/%b exp 01000/00000", fl, bub); end
    cyc(); exp_redir = exp_redir + 32'd1;
    clear_inputs(); jalr_EX = 1'b1;
    #1;
    checks++; if (fl !== 5'b01100) begin errors++; $display("FAIL jalr_only got %b exp %b", fl, 5'b01100); end
    cyc(); exp_redir = exp_redir + 32'd1;
    clear_inputs(); dcache_done = 1'b1;
    #1;
    checks++; if (fl !== 5'b00000 || bub !== 5'b00000) begin errors++; $display("FAIL done_in_run got %b/%b exp 00000/00000", fl, bub); end
    cyc();
    clear_inputs();
    #1;
    checks++; if (redirect_count !== exp_redir) begin errors++; $display("FAIL redir_count3 got %0d exp %0d", redirect_count, exp_redir); end
    checks++; if (fl !== 5'b00000) begin errors++; $display("FAIL done_no_state got %b exp %b", fl, 5'b00000); end
  endtask

  task automatic test_miss();
    dcache_miss_MEM = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) begin set_load_use(5'd3, 5'd3); br_EX = 1'b1; end
      else begin br_EX = 1'b0; mem_read_EX = 1'b0; end
      #1;
      checks++; if (bub !== 5'b11110 || fl !== 5'b00001) begin
        errors++; $display("FAIL miss_hold c%0d got %b/%b exp 11110/00001", c, bub, fl); end
      cyc();
    end
    clear_inputs(); dcache_miss_MEM = 1'b1; dcache_done = 1'b1;
    #1;
    checks++; if (bub !== 5'b00000 || fl !== 5'b00000) begin errors++; $display("FAIL miss_release got %b/%b exp 00000/00000", bub, fl); end
    cyc();
    exp_miss = exp_miss + 32'd1; exp_stall = exp_stall + 32'd4;
    clear_inputs();
    #1;
    checks++; if (miss_count !== exp_miss || stall_cycles !== exp_stall || redirect_count !== exp_redir) begin
      errors++; $display("FAIL miss_counters got %0d/%0d/%0d exp %0d/%0d/%0d", miss_count, stall_cycles, redirect_count, exp_miss, exp_stall, exp_redir); end
    dcache_miss_MEM = 1'b1;
    cyc();
    jal_ID = 1'b1; dcache_done = 1'b1;
    #1;
    checks++; if (fl !== 5'b01000 || bub !== 5'b00000) begin errors++; $display("FAIL miss_release_jal got %b/%b exp 01000/00000", fl, bub); end
    cyc();
    exp_miss = exp_miss + 32'd1; exp_stall = exp_stall + 32'd1; exp_redir = exp_redir + 32'd1;
    clear_inputs();
    #1;
    checks++; if (miss_count !== exp_miss || stall_cycles !== exp_stall || redirect_count !== exp_redir) begin
      errors++; $display("FAIL miss2_counters got %0d/%0d/%0d exp %0d/%0d/%0d", miss_count, stall_cycles, redirect_count, exp_miss, exp_stall, exp_redir); end
  endtask

  task automatic test_reset_mid_miss();
    dcache_miss_MEM = 1'b1;
    cyc(); cyc();
    rst = 1'b1;
    #1;
    checks++; if (fl !== 5'b11111 || bub !== 5'b00000) begin errors++; $display("FAIL midmiss_rst got %b/%b exp 11111/00000", fl, bub); end
    checks++; if (stall_cycles !== 32'd0 || miss_count !== 32'd0 || redirect_count !== 32'd0) begin
      errors++; $display("FAIL midmiss_counters got %0d/%0d/%0d exp 0/0/0", stall_cycles, miss_count, redirect_count); end
    cyc();
    rst = 1'b0; dcache_miss_MEM = 1'b0; dcache_done = 1'b1;
    cyc(); cyc();
    #1;
    checks++; if (fl !== 5'b00000 || bub !== 5'b00000) begin errors++; $display("FAIL midmiss_done_ignored got %b/%b exp 00000/00000", fl, bub); end
    cyc();
    clear_inputs();
    #1;
    checks++; if (stall_cycles !== 32'd0 || miss_count !== 32'd0) begin
      errors++; $display("FAIL midmiss_after got %0d/%0d exp 0/0", stall_cycles, miss_count); end
  endtask

  task automatic test_wrap();
    set_load_use(5'd9, 5'd9);
    for (int c = 0; c < 17; c++) cyc();
    clear_inputs();
    #1;
    checks++; if (stall4 !== 4'd1) begin errors++; $display("FAIL wrap_stall4 got %0d exp 1", stall4); end
    checks++; if (stall_cycles !== 32'd17) begin errors++; $display("FAIL wrap_stall32 got %0d exp 17", stall_cycles); end
    checks++; if (miss4 !== 4'd0 || redir4 !== 4'd0) begin errors++; $display("FAIL wrap_other4 got %0d/%0d exp 0/0", miss4, redir4); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_use();
    test_redirect();
    test_miss();
    test_reset_mid_miss();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32 core. It generates the per-stage `bubble*` (hold) and `flush*` (insert NOP) signals consumed by every IF/ID/EX/MEM/WB segment register. It runs a small state machine for post-reset pipeline clearing and data-cache miss stalls, and keeps hazard performance counters.

## Interface
Parameters:
- `INIT_FLUSH_CYCLES`, default 2: cycles of full-pipeline flush after reset release; legal range 1..15.
- `CNT_W`, default 32: width of each performance counter.

Ports:
- `clk`  in  1  pipeline clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `rs1_ID`, `rs2_ID`  in  5 each  source register indices in ID.
- `rs1_used_ID`, `rs2_used_ID`  in  1 each  ID instruction reads rs1 / rs2.
- `rd_EX`  in  5  destination register index in EX.
- `reg_write_en_EX`  in  1  EX instruction writes a GPR.
- `mem_read_EX`  in  1  EX instruction is a load.
- `br_EX`  in  1  taken branch resolved in EX.
- `jalr_EX`  in  1  JALR in EX.
- `jal_ID`  in  1  JAL in ID.
- `dcache_miss_MEM`  in  1  MEM access missed; held until serviced.
- `dcache_done`  in  1  one-cycle pulse; miss serviced.
- `bubbleF`, `bubbleD`, `bubbleE`, `bubbleM`, `bubbleW`  out  1 each  hold stage register.
- `flushF`, `flushD`, `flushE`, `flushM`, `flushW`  out  1 each  clear stage register to NOP.
- `stall_cycles`, `miss_count`, `redirect_count`  out  `CNT_W` each  performance counters.

## Operation
- States: INIT, RUN, MISS.
- INIT:
  - entered asynchronously on `rst`; down-counter loads `INIT_FLUSH_CYCLES`.
  - All five flush = 1, all bubbles = 0. This applies while `rst` is high and for exactly `INIT_FLUSH_CYCLES` rising edges after it falls.
  - Goes to RUN when the counter reaches 0.
- RUN: outputs default to 0. Rules apply in priority order:
  1. `dcache_miss_MEM`=1: assert MISS outputs this cycle; next state MISS; `miss_count`+1.
  2. `br_EX` | `jalr_EX`: flushD=1, flushE=1; `redirect_count`+1.
  3. `jal_ID`: flushD=1; `redirect_count`+1. Rules 2 and 3 in the same cycle count once.
  4. Load-use:
     - Condition: `mem_read_EX` & `reg_write_en_EX` & `rd_EX`≠0 & ((`rd_EX`==`rs1_ID` & `rs1_used_ID`) | (`rd_EX`==`rs2_ID` & `rs2_used_ID`)).
     - Response: bubbleF=1, bubbleD=1, flushE=1.
  - Redirect beats load-use, because the ID instruction is discarded. Redirect and `jal_ID` in the same cycle never trigger load-use.
- MISS:
  - bubbleF/D/E/M=1, bubbleW=0, flushW=1. WB receives NOPs so no GPR or CSR write repeats.
  - Redirect and load-use rules are ignored; EX inputs stay stable because EX is held.
  - On `dcache_done`=1, outputs follow RUN rules 2–4 in that same cycle (Mealy release), ignoring `dcache_miss_MEM`. Next state RUN.
- Counters:
  - All reset to 0 and wrap modulo 2^`CNT_W`.
  - `stall_cycles` increments on every cycle with bubbleF=1, in RUN or MISS only.
  - No counter changes in INIT.

## Timing
- Hazard outputs are combinational from state and inputs, valid before the next `clk` edge. Segment registers sample them at that edge.
- State and counters update on the `clk` rising edge. Counter outputs lag their event by 1 cycle.
- Reset values:
  - state INIT; flushF..flushW=1; bubbles 0.
  - counters 0; INIT down-counter = `INIT_FLUSH_CYCLES`.
- Miss latency: an N-cycle miss (miss seen at cycle 0, `dcache_done` at cycle N) holds bubbles for cycles 0..N-1, releases at N, and adds N to `stall_cycles`.
- `dcache_done` arriving in RUN is ignored.
- `rst` asserted mid-MISS or mid-INIT immediately returns to INIT and clears counters.

## Structure
- Shared package `hazard_pkg`:
  - state encodings `HZ_INIT`, `HZ_RUN`, `HZ_MISS` (2 bits);
  - `REG_ZERO` = 5'd0.
- One natural sub-module: `hazard_perf_cnt`, a single `CNT_W` wrap-around counter with increment enable and async reset. Instantiate it three times.
- FSM and priority logic stay in `hazard_ctrl`.

## Test plan
- Reset with `INIT_FLUSH_CYCLES`=2:
  - all flush=1 during `rst` and for 2 edges after release;
  - RUN on the 3rd edge, all outputs 0;
  - counters 0.
- Load-use: `mem_read_EX`=1, `reg_write_en_EX`=1, `rd_EX`=5, `rs2_ID`=5, `rs2_used_ID`=1 → bubbleF=bubbleD=flushE=1 for 1 cycle; `stall_cycles`=1. The same case with `rd_EX`=0 → no hazard.
- `br_EX`=1 together with the load-use condition and `jal_ID`=1 → flushD=flushE=1, bubbles 0, `redirect_count`+1 only.
- `dcache_miss_MEM` for 4 cycles, `dcache_done` at cycle 4:
  - bubbleF..M=1 and flushW=1 on cycles 0–3;
  - released at cycle 4;
  - `miss_count`=1, `stall_cycles`=4.
- `rst` pulsed at cycle 2 of a miss → immediate INIT outputs, counters 0; a later `dcache_done` is ignored.
- `CNT_W`=4, 17 load-use stalls → `stall_cycles` wraps to 1.
